fft_seq_ctrl: RTL and testbench
===============================

FFT_SEQ_CTRL -- requirements
Module: fft_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_FRAMES, default 64, meaning frames processed before done (1..255).
REQ-002 SHALL have parameter DATA_W, default 16, meaning FIR sample width.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port fir_valid  input  1  fir_d carries a valid sample this cycle.
REQ-006 SHALL have port fir_d  input  DATA_W  FIR output sample, signed.
REQ-007 SHALL have port fft_done  input  1  one-cycle pulse from FFT engine: current frame finished.
REQ-008 SHALL have port fft_rd_addr  input  4  FFT engine read address into the active frame.
REQ-009 SHALL have port fft_start  output  1  one-cycle pulse: frame ready, engine may begin.
REQ-010 SHALL have port fft_bank  output  1  bank index of the frame handed to the engine.
REQ-011 SHALL have port fft_rd_data  output  DATA_W  sample at fft_rd_addr of bank fft_bank.
REQ-012 SHALL have port frame_cnt  output  8  frames completed (fft_done accepted).
REQ-013 SHALL have port done  output  1  NUM_FRAMES frames completed; sticky.
REQ-014 SHALL have port overflow  output  1  sticky: at least one sample dropped.

Function
REQ-015 SHALL hold a ping-pong buffer of 2 banks x 16 samples x DATA_W.
REQ-016 SHALL write an accepted sample to buf[wr_bank][wr_ptr], then wr_ptr+1 (mod 16).
REQ-017 SHALL accept a sample only when fir_valid=1, done=0 and bank wr_bank is not full.
REQ-018 SHALL drop a non-accepted sample while done=0, set overflow=1, and leave wr_ptr unchanged.
REQ-019 SHALL, on the write with wr_ptr=15, mark wr_bank full and toggle wr_bank.
REQ-020 SHALL track per-bank state EMPTY/FILLING -> FULL -> IN_FFT -> EMPTY.
REQ-021 SHALL pulse fft_start one cycle after a bank becomes FULL when no bank is IN_FFT, and set fft_bank to that bank; the bank becomes IN_FFT.
REQ-022 SHALL, if a bank is FULL while the other is IN_FFT, pulse fft_start the cycle after fft_done releases the other.
REQ-023 SHALL, on fft_done while a bank is IN_FFT, set that bank EMPTY and frame_cnt+1 in the same cycle.
REQ-024 SHALL ignore fft_done when no bank is IN_FFT.
REQ-025 SHALL, when fft_done frees bank wr_bank in the same cycle fir_valid arrives for it, accept the sample.
REQ-026 SHALL never assert fft_start for two frames at once; at most one bank IN_FFT.
REQ-027 SHALL register fft_rd_data: value of buf[fft_bank][fft_rd_addr] one cycle after the address.
REQ-028 SHALL set done=1 the cycle after frame_cnt reaches NUM_FRAMES; then no acceptance, no fft_start, no overflow updates, frame_cnt frozen.
REQ-029 SHALL not modify an IN_FFT bank under any input sequence.

Reset
REQ-030 SHALL, on rst=0, asynchronously clear fft_start, fft_bank, fft_rd_data, frame_cnt, done, overflow, wr_ptr, wr_bank and all bank states to EMPTY.
REQ-031 SHALL abandon any in-flight frame on reset mid-operation; fft_done after reset release is ignored per REQ-024.
REQ-032 SHALL not require buffer contents to be cleared by reset.

Structure
REQ-033 SHALL place FRAME_LEN=16, the bank-state enumeration and DATA_W default in shared package fas_pkg.
REQ-034 SHALL implement the 2x16 buffer as one sub-module fft_pingpong_buf (1 write port, 1 registered read port).

Verification
REQ-035 SHALL check: 16 samples 0..15 on consecutive cycles -> fft_start pulse one cycle after 16th, fft_bank=0; read addr 5 -> fft_rd_data=5 next cycle.
REQ-036 SHALL check: 32 consecutive samples with no fft_done -> second fft_start absent; fft_done -> fft_start fft_bank=1 next cycle, frame_cnt=1.
REQ-037 SHALL check: 33 samples with no fft_done -> 33rd dropped, overflow=1, wr_ptr=0.
REQ-038 SHALL check: fft_done and 1st sample for the freed bank same cycle -> sample accepted, overflow stays 0.
REQ-039 SHALL check: NUM_FRAMES=2, two frames completed -> done=1; further samples and fft_done change nothing.
REQ-040 SHALL check: rst low mid-frame (wr_ptr=7) -> all outputs 0 immediately; stray fft_done ignored; next 16 samples start bank 0.

Source files
------------

// File: rtl/fas_pkg.sv
// Shared definitions for the FFT frame sequencer: frame geometry and the
// per-bank lifecycle state.
package fas_pkg;

  localparam int unsigned FRAME_LEN      = 16;
  localparam int unsigned PTR_W          = 4;
  localparam int unsigned DATA_W_DEFAULT = 16;

  // A bank that is being filled is simply Empty with wr_bank pointing at it.
  typedef enum logic [1:0] {
    BankEmpty,
    BankFull,
    BankInFft
  } bank_state_e;

endpackage

// File: rtl/fft_pingpong_buf.sv
// Two banks of FRAME_LEN samples: one write port, one registered read port.
// Storage is not reset; only the read register is.
module fft_pingpong_buf
  import fas_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [PTR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_bank,
  input  logic [PTR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:2*FRAME_LEN-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_bank, wr_addr}] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[{rd_bank, rd_addr}];
    end
  end

endmodule

// File: rtl/fft_seq_ctrl.sv
// Ping-pong frame sequencer between a FIR sample stream and an FFT engine:
// fills 16-sample banks, hands full banks to the engine, counts finished frames.
module fft_seq_ctrl
  import fas_pkg::*;
#(
  parameter int unsigned NUM_FRAMES = 64,
  parameter int unsigned DATA_W     = DATA_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fir_valid,
  input  logic signed [DATA_W-1:0] fir_d,
  input  logic                     fft_done,
  input  logic [3:0]               fft_rd_addr,
  output logic                     fft_start,
  output logic                     fft_bank,
  output logic signed [DATA_W-1:0] fft_rd_data,
  output logic [7:0]               frame_cnt,
  output logic                     done,
  output logic                     overflow
);

  localparam logic [PTR_W-1:0] PtrLast  = PTR_W'(FRAME_LEN - 1);
  localparam logic [7:0]       CntLast  = 8'(NUM_FRAMES);
  localparam logic [7:0]       CntPenul = 8'(NUM_FRAMES - 1);

  bank_state_e      bank_q [2];
  bank_state_e      bank_d [2];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             wr_bank_q, wr_bank_d;
  logic             fft_start_q, fft_start_d;
  logic             fft_bank_q, fft_bank_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic             done_q, done_d;
  logic             overflow_q, overflow_d;

  logic busy, busy_bank, release_ok, wr_free, accept, drop;
  logic full0, full1, last_frame, start, start_bank;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_q[0]   <= BankEmpty;
      bank_q[1]   <= BankEmpty;
      wr_ptr_q    <= '0;
      wr_bank_q   <= 1'b0;
      fft_start_q <= 1'b0;
      fft_bank_q  <= 1'b0;
      frame_cnt_q <= '0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      bank_q      <= bank_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_bank_q   <= wr_bank_d;
      fft_start_q <= fft_start_d;
      fft_bank_q  <= fft_bank_d;
      frame_cnt_q <= frame_cnt_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
    end
  end

  // Decode of this cycle's events from the current bank states and inputs.
  always_comb begin
    busy       = (bank_q[0] == BankInFft) || (bank_q[1] == BankInFft);
    busy_bank  = (bank_q[1] == BankInFft);
    release_ok = fft_done && busy && !done_q;
    // A bank freed by fft_done this cycle may take the incoming sample.
    wr_free    = (bank_q[wr_bank_q] == BankEmpty) || (release_ok && (busy_bank == wr_bank_q));
    accept     = fir_valid && !done_q && wr_free;
    drop       = fir_valid && !done_q && !wr_free;
    full0      = (bank_q[0] == BankFull);
    full1      = (bank_q[1] == BankFull);
    // Both full means wr_bank has wrapped onto the older frame.
    start_bank = (full0 && full1) ? wr_bank_q : full1;
    // No new frame is launched once the final frame has been counted.
    last_frame = (frame_cnt_q == CntLast) || (release_ok && (frame_cnt_q == CntPenul));
    start      = (full0 || full1) && (!busy || release_ok) && !done_q && !last_frame;
  end

  always_comb begin
    bank_d      = bank_q;
    wr_ptr_d    = wr_ptr_q;
    wr_bank_d   = wr_bank_q;
    frame_cnt_d = frame_cnt_q;
    fft_start_d = start;
    fft_bank_d  = fft_bank_q;
    done_d      = done_q || (frame_cnt_q == CntLast);
    overflow_d  = overflow_q || drop;

    if (release_ok) begin
      bank_d[busy_bank] = BankEmpty;
      frame_cnt_d       = frame_cnt_q + 8'd1;
    end
    if (start) begin
      bank_d[start_bank] = BankInFft;
      fft_bank_d         = start_bank;
    end
    if (accept) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (wr_ptr_q == PtrLast) begin
        bank_d[wr_bank_q] = BankFull;
        wr_bank_d         = ~wr_bank_q;
      end
    end
  end

  fft_pingpong_buf #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept),
    .wr_bank (wr_bank_q),
    .wr_addr (wr_ptr_q),
    .wr_data (fir_d),
    .rd_bank (fft_bank_q),
    .rd_addr (fft_rd_addr),
    .rd_data (fft_rd_data)
  );

  assign fft_start = fft_start_q;
  assign fft_bank  = fft_bank_q;
  assign frame_cnt = frame_cnt_q;
  assign done      = done_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Bench for fft_seq_ctrl: a queue-based frame model checked every cycle on a
// long-running instance, plus directed literal checks (incl. a NUM_FRAMES=2 instance).
module tb_fft_seq_ctrl;

  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fir_valid = 1'b0;
  logic [DW-1:0] fir_d = '0;
  logic          fft_done = 1'b0;
  logic [3:0]    fft_rd_addr = '0;

  logic          fft_start, fft_bank, done, overflow;
  logic [DW-1:0] fft_rd_data;
  logic [7:0]    frame_cnt;

  logic          s_start, s_bank, s_done, s_ovf;
  logic [DW-1:0] s_rd;
  logic [7:0]    s_cnt;

  always #5 clk = ~clk;

  fft_seq_ctrl #(.NUM_FRAMES(64), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .fir_valid(fir_valid), .fir_d(fir_d), .fft_done(fft_done),
    .fft_rd_addr(fft_rd_addr), .fft_start(fft_start), .fft_bank(fft_bank),
    .fft_rd_data(fft_rd_data), .frame_cnt(frame_cnt), .done(done), .overflow(overflow)
  );

  fft_seq_ctrl #(.NUM_FRAMES(2), .DATA_W(DW)) dut2 (
    .clk(clk), .rst(rst), .fir_valid(fir_valid), .fir_d(fir_d), .fft_done(fft_done),
    .fft_rd_addr(fft_rd_addr), .fft_start(s_start), .fft_bank(s_bank),
    .fft_rd_data(s_rd), .frame_cnt(s_cnt), .done(s_done), .overflow(s_ovf)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model of the NUM_FRAMES=64 instance.
  logic [DW-1:0] m_mem [32];
  bit            m_known [32];
  int            m_wbank, m_wptr, m_busy_bank, m_frames;
  int            m_pend [$];
  bit            m_busy, m_done, m_ovf;
  bit            e_start;
  int            e_bank;
  logic [DW-1:0] e_rd;
  bit            e_rd_known;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wbank = 0; m_wptr = 0; m_busy = 0; m_busy_bank = 0; m_frames = 0;
    m_done = 0; m_ovf = 0; m_pend.delete();
    e_start = 0; e_bank = 0; e_rd = '0; e_rd_known = 1;
  endtask

  // Effect of one rising edge given the inputs currently driven.
  task automatic model_edge();
    bit rel, in_pend, free, acc, fin, st, nxt_done;
    int idx;
    rel = fft_done && m_busy && !m_done;
    in_pend = 0;
    foreach (m_pend[i]) if (m_pend[i] == m_wbank) in_pend = 1;
    free = (!in_pend && !(m_busy && m_busy_bank == m_wbank)) || (rel && m_busy_bank == m_wbank);
    acc = fir_valid && !m_done && free;
    idx = e_bank * 16 + int'(fft_rd_addr);
    e_rd_known = m_known[idx];
    e_rd = m_mem[idx];
    fin = (m_frames == 64) || (rel && m_frames + 1 == 64);
    st = (m_pend.size() > 0) && (!m_busy || rel) && !m_done && !fin;
    nxt_done = m_done || (m_frames == 64);
    if (rel) begin
      m_busy = 0;
      m_frames++;
    end
    e_start = st;
    if (st) begin
      e_bank = m_pend.pop_front();
      m_busy = 1;
      m_busy_bank = e_bank;
    end
    if (fir_valid && !m_done && !acc) m_ovf = 1;
    if (acc) begin
      m_mem[m_wbank * 16 + m_wptr] = fir_d;
      m_known[m_wbank * 16 + m_wptr] = 1;
      if (m_wptr == 15) begin
        m_pend.push_back(m_wbank);
        m_wbank ^= 1;
        m_wptr = 0;
      end else begin
        m_wptr++;
      end
    end
    m_done = nxt_done;
  endtask

  task automatic compare_all();
    check("m_fft_start", 32'(fft_start), 32'(e_start));
    check("m_fft_bank", 32'(fft_bank), e_bank);
    check("m_frame_cnt", 32'(frame_cnt), m_frames);
    check("m_done", 32'(done), 32'(m_done));
    check("m_overflow", 32'(overflow), 32'(m_ovf));
    if (e_rd_known) check("m_fft_rd_data", 32'(fft_rd_data), 32'(e_rd));
  endtask

  // Called at a falling edge; returns at the next falling edge after checking.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit dn);
    fir_valid = v;
    fir_d = d;
    fft_done = dn;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
    fir_valid = 1'b0;
    fft_done = 1'b0;
  endtask

  task automatic send(input int n, input int base);
    for (int i = 0; i < n; i++) step(1'b1, DW'(base + i), 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
  endtask

  task automatic hard_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    foreach (m_known[i]) m_known[i] = 0;
    foreach (m_mem[i]) m_mem[i] = '0;
    hard_reset();
    check("rst_start", 32'(fft_start), 0);
    check("rst_cnt", 32'(frame_cnt), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_rd", 32'(fft_rd_data), 0);

    // 16 samples fill bank 0; engine starts on bank 0.
    fft_rd_addr = 4'd5;
    send(16, 0);
    idle(1);
    check("s1_start", 32'(fft_start), 1);
    check("s1_bank", 32'(fft_bank), 0);
    idle(1);
    check("s1_rd5", 32'(fft_rd_data), 5);
    check("s1_pulse", 32'(fft_start), 0);

    // 32 samples: second bank waits until fft_done frees bank 0.
    hard_reset();
    fft_rd_addr = 4'd3;
    send(32, 100);
    idle(3);
    check("s2_nostart", 32'(fft_start), 0);
    step(1'b0, '0, 1'b1);
    check("s2_start", 32'(fft_start), 1);
    check("s2_bank", 32'(fft_bank), 1);
    check("s2_cnt", 32'(frame_cnt), 1);
    idle(1);
    check("s2_rd", 32'(fft_rd_data), 119);

    // 33 samples: last one dropped, write pointer stays at bank 0 index 0.
    hard_reset();
    fft_rd_addr = 4'd0;
    send(33, 200);
    check("s3_ovf", 32'(overflow), 1);
    step(1'b0, '0, 1'b1);
    send(16, 16'h500);
    step(1'b0, '0, 1'b1);
    check("s3_start_b0", 32'(fft_bank), 0);
    idle(1);
    check("s3_wrptr0", 32'(fft_rd_data), 32'h500);

    // fft_done and a sample for the freed bank in the same cycle.
    hard_reset();
    fft_rd_addr = 4'd0;
    send(32, 16'h40);
    step(1'b1, 16'h1234, 1'b1);
    check("s4_ovf", 32'(overflow), 0);
    check("s4_start_b1", 32'(fft_bank), 1);
    send(15, 16'h41);
    idle(1);
    check("s4_ovf2", 32'(overflow), 0);
    step(1'b0, '0, 1'b1);
    idle(1);
    check("s4_rd", 32'(fft_rd_data), 32'h1234);

    // NUM_FRAMES=2 instance: done after two frames, then frozen.
    hard_reset();
    send(16, 1);
    idle(1);
    send(16, 16'h20);
    step(1'b0, '0, 1'b1);
    send(16, 16'h30);
    step(1'b0, '0, 1'b1);
    check("s5_cnt2", 32'(s_cnt), 2);
    check("s5_nostart", 32'(s_start), 0);
    check("s5_done_late", 32'(s_done), 0);
    idle(1);
    check("s5_done", 32'(s_done), 1);
    send(5, 16'h70);
    step(1'b0, '0, 1'b1);
    idle(1);
    check("s5_cnt_frozen", 32'(s_cnt), 2);
    check("s5_ovf", 32'(s_ovf), 0);
    check("s5_start_frozen", 32'(s_start), 0);
    check("s5_done_sticky", 32'(s_done), 1);

    // Asynchronous reset mid-frame, then a stray fft_done.
    hard_reset();
    fft_rd_addr = 4'd5;
    send(16, 16'h60);
    idle(1);
    step(1'b0, '0, 1'b1);
    send(7, 16'h90);
    #2 rst = 1'b0;
    #1;
    check("s6_start", 32'(fft_start), 0);
    check("s6_bank", 32'(fft_bank), 0);
    check("s6_rd", 32'(fft_rd_data), 0);
    check("s6_cnt", 32'(frame_cnt), 0);
    check("s6_done", 32'(done), 0);
    check("s6_ovf", 32'(overflow), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, '0, 1'b1);
    check("s6_stray", 32'(frame_cnt), 0);
    send(16, 16'hA0);
    idle(1);
    check("s6_restart", 32'(fft_start), 1);
    check("s6_restart_b0", 32'(fft_bank), 0);
    idle(1);
    check("s6_rd_new", 32'(fft_rd_data), 32'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
